// File: rtl/uart_autobaud_ctrl.sv
// Autobaud controller: times one 0x55 sync character on RX and loads the derived baud divisor.
// Define UART_AUTOBAUD_FRCTN_EN to also produce the 3-bit fractional divisor.
module uart_autobaud_ctrl #(
    parameter logic [12:0] DEFAULT_BAUD_VAL = 13'd1,
    parameter int unsigned CNT_W            = 20
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic        ABORT,
    input  logic        RX,
    output logic [12:0] BAUD_VAL,
    output logic [2:0]  BAUD_VAL_FRACTION,
    output logic        BAUD_LOAD,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_FALL,
        S_MEASURE,
        S_CHECK,
        S_UPDATE
    } state_t;

    localparam int unsigned      XW      = CNT_W + 3;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
`ifdef UART_AUTOBAUD_FRCTN_EN
    localparam logic [CNT_W:0]   ROUND_ADD = 8;
`else
    localparam logic [CNT_W:0]   ROUND_ADD = 64;
`endif

    state_t             state_q, state_d;
    logic               rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   s_q, s_d;
    logic               s_seen_q, s_seen_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [2:0]         e_q, e_d;
    logic [12:0]        baud_q, baud_d;

    logic               fall, rise;
    logic [XW-1:0]      n_x, s8_x, lo_x, hi_x;
    logic [CNT_W:0]     t_sum;
    logic [31:0]        q_full, q_m1;
    logic [12:0]        baud_calc;
    logic               check_ok;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign fall = rx_prev_q & ~rx_sync_q;
    assign rise = ~rx_prev_q & rx_sync_q;

    // Symmetry window on the measurement, then divisor = round(N/128) - 1, saturated.
    always_comb begin
        n_x       = {3'b000, n_q};
        s8_x      = {s_q, 3'b000};
        lo_x      = n_x - (n_x >> 2);
        hi_x      = n_x + (n_x >> 2);
        t_sum     = {1'b0, n_q} + ROUND_ADD;
        q_full    = 32'(t_sum >> 7);
        q_m1      = q_full - 32'd1;
        baud_calc = (q_m1 > 32'd8191) ? 13'h1FFF : q_m1[12:0];
        check_ok  = s_seen_q && (s8_x >= lo_x) && (s8_x <= hi_x) && (q_full != 32'd0);
    end

`ifdef UART_AUTOBAUD_FRCTN_EN
    logic [2:0] frac_q, frac_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            frac_q <= '0;
        end else begin
            frac_q <= frac_d;
        end
    end

    always_comb begin
        frac_d = frac_q;
        if (state_q == S_CHECK && check_ok && !ABORT) begin
            frac_d = t_sum[6:4];
        end
    end

    assign BAUD_VAL_FRACTION = frac_q;
`else
    assign BAUD_VAL_FRACTION = '0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            s_q      <= '0;
            s_seen_q <= 1'b0;
            n_q      <= '0;
            e_q      <= '0;
            baud_q   <= DEFAULT_BAUD_VAL;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            s_q      <= s_d;
            s_seen_q <= s_seen_d;
            n_q      <= n_d;
            e_q      <= e_d;
            baud_q   <= baud_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        s_d       = s_q;
        s_seen_d  = s_seen_q;
        n_d       = n_q;
        e_d       = e_q;
        baud_d    = baud_q;
        BUSY      = (state_q != S_IDLE);
        DONE      = 1'b0;
        ERR       = 1'b0;
        BAUD_LOAD = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START && !ABORT) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (rx_sync_q) begin
                    state_d = S_WAIT_FALL;
                end
            end
            S_WAIT_FALL: begin
                if (fall) begin
                    cnt_d    = '0;
                    s_d      = '0;
                    s_seen_d = 1'b0;
                    e_d      = '0;
                    state_d  = S_MEASURE;
                end
            end
            S_MEASURE: begin
                cnt_d = cnt_q + CNT_ONE;
                // Overflow is tested first so it wins over a coincident falling edge.
                if (cnt_q == '1) begin
                    ERR     = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    if (rise && !s_seen_q) begin
                        s_d      = cnt_d;
                        s_seen_d = 1'b1;
                    end
                    if (fall) begin
                        e_d = e_q + 3'd1;
                        if (e_q == 3'd3) begin
                            n_d     = cnt_d;
                            state_d = S_CHECK;
                        end
                    end
                end
            end
            S_CHECK: begin
                if (check_ok) begin
                    baud_d  = baud_calc;
                    state_d = S_UPDATE;
                end else begin
                    ERR     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_UPDATE: begin
                BAUD_LOAD = 1'b1;
                DONE      = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // In UPDATE the divisor has already changed, so its strobe is left intact.
        if (ABORT && state_q != S_IDLE) begin
            state_d = S_IDLE;
            if (state_q != S_UPDATE) begin
                ERR    = 1'b0;
                baud_d = baud_q;
            end
        end
    end

    assign BAUD_VAL = baud_q;

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Self-checking bench for uart_autobaud_ctrl: directed scenarios plus randomized bit periods
// checked against an arithmetic model of the divisor rules.
module tb_uart_autobaud_ctrl;

    logic        CLK = 1'b0;
    logic        RESET, START, ABORT, RX;
    logic [12:0] BAUD_VAL;
    logic [2:0]  BAUD_VAL_FRACTION;
    logic        BAUD_LOAD, BUSY, DONE, ERR;

    logic        START10, ABORT10, RX10;
    logic [12:0] BAUD_VAL10;
    logic [2:0]  FRAC10;
    logic        LOAD10, BUSY10, DONE10, ERR10;

    uart_autobaud_ctrl dut (
        .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT), .RX(RX),
        .BAUD_VAL(BAUD_VAL), .BAUD_VAL_FRACTION(BAUD_VAL_FRACTION),
        .BAUD_LOAD(BAUD_LOAD), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    uart_autobaud_ctrl #(.DEFAULT_BAUD_VAL(13'd1), .CNT_W(10)) dut10 (
        .CLK(CLK), .RESET(RESET), .START(START10), .ABORT(ABORT10), .RX(RX10),
        .BAUD_VAL(BAUD_VAL10), .BAUD_VAL_FRACTION(FRAC10),
        .BAUD_LOAD(LOAD10), .BUSY(BUSY10), .DONE(DONE10), .ERR(ERR10)
    );

    always #5 CLK = ~CLK;

`ifdef UART_AUTOBAUD_FRCTN_EN
    localparam int RND   = 8;
    localparam bit FR_EN = 1'b1;
`else
    localparam int RND   = 64;
    localparam bit FR_EN = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int load_cnt = 0, done_cnt = 0, err_cnt = 0;
    int res_cyc = -1, busy_fall_cyc = -1;
    logic busy_prev = 1'b0;

    int b_load, b_done, b_err;
    int fall_at[5];
    int cur_bv, cur_fr;

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (BAUD_LOAD) load_cnt++;
        if (DONE) begin done_cnt++; res_cyc = cyc; end
        if (ERR)  begin err_cnt++;  res_cyc = cyc; end
        if (busy_prev && !BUSY) busy_fall_cyc = cyc;
        busy_prev = BUSY;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic snap();
        b_load = load_cnt;
        b_done = done_cnt;
        b_err  = err_cnt;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        tick(1);
        START = 1'b0;
    endtask

    // 0x55 LSB first at p clocks per bit; records the cycle of each falling edge.
    task automatic send_55(input int p);
        logic [7:0] ch;
        int k;
        ch = 8'h55;
        k  = 0;
        fall_at[k++] = cyc;
        RX = 1'b0;
        tick(p);
        for (int i = 0; i < 8; i++) begin
            RX = ch[i];
            if (!ch[i]) fall_at[k++] = cyc;
            tick(p);
        end
        RX = 1'b1;
        tick(p);
    endtask

    task automatic model(input int n, input int s, output bit ok, output int bv, output int fr);
        int t, q;
        t  = n + RND;
        q  = t / 128;
        ok = (s != 0) && (8 * s >= n - n / 4) && (8 * s <= n + n / 4) && (q >= 1);
        bv = (q - 1 > 8191) ? 8191 : q - 1;
        fr = FR_EN ? (t % 128) / 16 : 0;
    endtask

    task automatic finish_check(input string tag, input int n, input int s, input int fall4);
        bit ok;
        int bv, fr;
        model(n, s, ok, bv, fr);
        for (int k = 0; k < 200 && (done_cnt + err_cnt) == (b_done + b_err); k++) tick(1);
        tick(3);
        if (ok) begin
            cur_bv = bv;
            cur_fr = fr;
            chk({tag, "_done"}, done_cnt - b_done, 1);
            chk({tag, "_load"}, load_cnt - b_load, 1);
            chk({tag, "_err"}, err_cnt - b_err, 0);
            chk({tag, "_lat"}, res_cyc, fall4 + 4);
        end else begin
            chk({tag, "_done"}, done_cnt - b_done, 0);
            chk({tag, "_load"}, load_cnt - b_load, 0);
            chk({tag, "_err"}, err_cnt - b_err, 1);
            chk({tag, "_lat"}, res_cyc, fall4 + 3);
        end
        chk({tag, "_baud"}, BAUD_VAL, cur_bv);
        chk({tag, "_frac"}, BAUD_VAL_FRACTION, cur_fr);
        chk({tag, "_busyfall"}, busy_fall_cyc, res_cyc + 1);
        chk({tag, "_idle"}, BUSY, 0);
    endtask

    task automatic calibrate(input string tag, input int p);
        snap();
        pulse_start();
        tick(5);
        send_55(p);
        finish_check(tag, 8 * p, p, fall_at[4]);
    endtask

    initial begin
        int p, c0, err_seen;
        RESET = 1'b1; START = 1'b0; ABORT = 1'b0; RX = 1'b1;
        START10 = 1'b0; ABORT10 = 1'b0; RX10 = 1'b1;
        tick(3);
        RESET = 1'b0;
        tick(1);
        chk("rst_baud", BAUD_VAL, 1);
        chk("rst_frac", BAUD_VAL_FRACTION, 0);
        chk("rst_load", BAUD_LOAD, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_err", ERR, 0);
        chk("rst10_baud", BAUD_VAL10, 1);
        chk("rst10_frac", FRAC10, 0);
        cur_bv = 1;
        cur_fr = 0;

        snap();
        pulse_start();
        chk("busy_rise", BUSY, 1);
        tick(5);
        send_55(64);
        finish_check("p64", 512, 64, fall_at[4]);

        calibrate("p68", 68);

        // Short low pulse before the sync character skews S against N.
        snap();
        pulse_start();
        tick(5);
        RX = 1'b0;
        tick(10);
        RX = 1'b1;
        tick(90);
        send_55(64);
        finish_check("glitch", 484, 10, fall_at[3]);

        RX = 1'b0;
        tick(5);
        snap();
        pulse_start();
        tick(40);
        chk("arm_hold_busy", BUSY, 1);
        chk("arm_hold_done", done_cnt - b_done, 0);
        RX = 1'b1;
        tick(10);
        send_55(64);
        finish_check("arm", 512, 64, fall_at[4]);

        snap();
        pulse_start();
        tick(5);
        RX = 1'b0;
        tick(100);
        ABORT = 1'b1;
        tick(1);
        ABORT = 1'b0;
        chk("abort_busy", BUSY, 0);
        RX = 1'b1;
        tick(20);
        chk("abort_done", done_cnt - b_done, 0);
        chk("abort_err", err_cnt - b_err, 0);
        chk("abort_load", load_cnt - b_load, 0);
        chk("abort_baud", BAUD_VAL, cur_bv);
        calibrate("after_abort", 72);

        START = 1'b1;
        ABORT = 1'b1;
        tick(1);
        START = 1'b0;
        ABORT = 1'b0;
        chk("start_abort_busy", BUSY, 0);

        calibrate("tiny_p6", 6);
        calibrate("tiny_p8", 8);
        for (int i = 0; i < 6; i++) begin
            p = $urandom_range(5, 300);
            calibrate($sformatf("rnd%0d_p%0d", i, p), p);
        end

        calibrate("pre_rst", 64);
        pulse_start();
        tick(5);
        RX = 1'b0;
        tick(50);
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
        chk("midrst_baud", BAUD_VAL, 1);
        chk("midrst_frac", BAUD_VAL_FRACTION, 0);
        chk("midrst_busy", BUSY, 0);
        chk("midrst_load", BAUD_LOAD, 0);
        chk("midrst_done", DONE, 0);
        chk("midrst_err", ERR, 0);
        RX = 1'b1;
        cur_bv = 1;
        cur_fr = 0;

        START10 = 1'b1;
        tick(1);
        START10 = 1'b0;
        tick(5);
        RX10 = 1'b0;
        c0 = cyc;
        tick(10);
        RX10 = 1'b1;
        err_seen = -1;
        for (int k = 0; k < 1500 && err_seen < 0; k++) begin
            tick(1);
            if (ERR10) err_seen = cyc;
        end
        chk("ovf_err_cyc", err_seen, c0 + 1026);
        tick(1);
        chk("ovf_busy", BUSY10, 0);
        chk("ovf_load", LOAD10, 0);
        chk("ovf_done", DONE10, 0);
        chk("ovf_baud", BAUD_VAL10, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
